// File: rtl/instruction_fetch.sv
// Program sequencer in front of a combinational instruction ROM: owns the ROM
// address, resolves NOP delays and JMPs locally, and issues everything else.
module instruction_fetch #(
  parameter logic [3:0] OP_NOP = 4'd0,
  parameter logic [3:0] OP_JMP = 4'd1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oIP,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iReady
);

  typedef enum logic [1:0] {
    FETCH,
    DELAY,
    ISSUE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] ip_reg, ip_next;
  logic [27:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;
  logic [23:0] count_reg, count_next;

  logic [3:0]  opcode;
  logic [23:0] delay_count;
  logic [15:0] jump_target;

  assign opcode      = iInstruction[27:24];
  assign delay_count = iInstruction[23:0];
  assign jump_target = iInstruction[15:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= FETCH;
      ip_reg    <= 16'd0;
      instr_reg <= 28'd0;
      valid_reg <= 1'b0;
      count_reg <= 24'd0;
    end else begin
      state_reg <= state_next;
      ip_reg    <= ip_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ip_next    = ip_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    count_next = count_reg;

    case (state_reg)
      FETCH: begin
        if (opcode == OP_NOP) begin
          if (delay_count == 24'd0) begin
            ip_next = ip_reg + 16'd1;
          end else begin
            count_next = delay_count;
            state_next = DELAY;
          end
        end else if (opcode == OP_JMP) begin
          ip_next = jump_target;
        end else begin
          instr_next = iInstruction;
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end

      DELAY: begin
        // A zero count cannot be entered; treating it like 1 keeps the FSM from sticking.
        if (count_reg <= 24'd1) begin
          count_next = 24'd0;
          ip_next    = ip_reg + 16'd1;
          state_next = FETCH;
        end else begin
          count_next = count_reg - 24'd1;
        end
      end

      ISSUE: begin
        if (iReady) begin
          valid_next = 1'b0;
          ip_next    = ip_reg + 16'd1;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign oIP          = ip_reg;
  assign oInstruction = instr_reg;
  assign oValid       = valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural ROM driven by oIP, with
// hand-computed expectations checked through immediate assertions.
module tb_instruction_fetch;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_JMP = 4'd1;
  localparam logic [3:0] OP_STO = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_ADD = 4'd6;
  localparam logic [3:0] OP_LED = 4'd7;

  localparam logic [27:0] W_STO = {OP_STO, 8'h00, 16'h8000};
  localparam logic [27:0] W_MUL = {OP_MUL, 8'h01, 8'h02, 8'h03};
  localparam logic [27:0] W_ADD = {OP_ADD, 8'h04, 8'h05, 8'h06};
  localparam logic [27:0] W_LED = {OP_LED, 8'h0A, 8'h0B, 8'h0C};

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady = 1'b0;

  logic [27:0] rom [0:65535];

  int checks = 0;
  int errors = 0;

  assign iInstruction = rom[oIP];

  always #5 Clock = ~Clock;

  instruction_fetch #(
    .OP_NOP(OP_NOP),
    .OP_JMP(OP_JMP)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .oInstruction (oInstruction),
    .oValid       (oValid),
    .iReady       (iReady)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] ip, input logic valid,
                             input logic [27:0] instr);
    check({tag, ".ip"}, {16'd0, oIP}, {16'd0, ip});
    check({tag, ".valid"}, {31'd0, oValid}, {31'd0, valid});
    check({tag, ".instr"}, {4'd0, oInstruction}, {4'd0, instr});
  endtask

  // Returns 1 ns after the rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 28'd0;
  endtask

  initial begin
    // Program A: NOP 3, STO, MUL, ADD, NOP 0 x3, JMP 0
    clear_rom();
    rom[0] = {OP_NOP, 24'd3};
    rom[1] = W_STO;
    rom[2] = W_MUL;
    rom[3] = W_ADD;
    rom[7] = {OP_JMP, 8'h00, 16'd0};
    iReady = 1'b1;
    #12;
    check_state("reset", 16'd0, 1'b0, 28'd0);
    $display("step reset: ip=%h valid=%b instr=%h", oIP, oValid, oInstruction);
    tick();
    Reset = 1'b1;

    // NOP 3 holds for 4 edges, ip moves on the 4th
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_state($sformatf("nop3.e%0d", i), 16'd0, 1'b0, 28'd0);
    end
    tick();
    check_state("nop3.e4", 16'd1, 1'b0, 28'd0);
    tick();
    check_state("issue_sto", 16'd1, 1'b1, W_STO);
    $display("step issue: ip=%h valid=%b instr=%h", oIP, oValid, oInstruction);
    tick();
    check_state("accept_sto", 16'd2, 1'b0, W_STO);
    tick();
    check_state("issue_mul", 16'd2, 1'b1, W_MUL);
    tick();
    check_state("accept_mul", 16'd3, 1'b0, W_MUL);

    // Backpressure: ADD held for 5 edges with iReady low
    iReady = 1'b0;
    tick();
    check_state("issue_add", 16'd3, 1'b1, W_ADD);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_state($sformatf("stall.c%0d", i), 16'd3, 1'b1, W_ADD);
    end
    iReady = 1'b1;
    tick();
    check_state("accept_add", 16'd4, 1'b0, W_ADD);
    $display("step stall release: ip=%h valid=%b", oIP, oValid);

    // NOP 0 at 4,5,6 then JMP 0 at 7
    tick(); check_state("nop0.a4", 16'd5, 1'b0, W_ADD);
    tick(); check_state("nop0.a5", 16'd6, 1'b0, W_ADD);
    tick(); check_state("nop0.a6", 16'd7, 1'b0, W_ADD);
    tick(); check_state("jmp0", 16'd0, 1'b0, W_ADD);
    $display("step jmp: ip=%h valid=%b", oIP, oValid);
    // Loop back through NOP 3 and reissue STO
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_state($sformatf("loop.nop.e%0d", i), 16'd0, 1'b0, W_ADD);
    end
    tick(); check_state("loop.nop.e4", 16'd1, 1'b0, W_ADD);
    tick(); check_state("loop.issue_sto", 16'd1, 1'b1, W_STO);

    // Program B: NOP 0, JMP FFFF, LED at FFFF (wrap)
    Reset = 1'b0;
    clear_rom();
    rom[0]     = {OP_NOP, 24'd0};
    rom[1]     = {OP_JMP, 8'h00, 16'hFFFF};
    rom[16'hFFFF] = W_LED;
    #1;
    check_state("reset2", 16'd0, 1'b0, 28'd0);
    Reset = 1'b1;
    tick(); check_state("nop0.adv", 16'd1, 1'b0, 28'd0);
    tick(); check_state("jmp_ffff", 16'hFFFF, 1'b0, 28'd0);
    tick(); check_state("issue_led", 16'hFFFF, 1'b1, W_LED);
    tick(); check_state("wrap", 16'd0, 1'b0, W_LED);
    $display("step wrap: ip=%h valid=%b", oIP, oValid);

    // Program C: NOP 4000 then STO; reset during delay and during issue
    Reset = 1'b0;
    clear_rom();
    rom[0] = {OP_NOP, 24'd4000};
    rom[1] = W_STO;
    iReady = 1'b0;
    #1;
    Reset = 1'b1;
    repeat (2000) tick();
    check_state("delay_mid", 16'd0, 1'b0, 28'd0);
    #2;
    Reset = 1'b0;
    #1;
    check_state("async_rst_delay", 16'd0, 1'b0, 28'd0);
    Reset = 1'b1;
    repeat (4000) tick();
    check_state("full_delay.e4000", 16'd0, 1'b0, 28'd0);
    tick();
    check_state("full_delay.e4001", 16'd1, 1'b0, 28'd0);
    tick();
    check_state("issue_sto2", 16'd1, 1'b1, W_STO);
    #2;
    Reset = 1'b0;
    #1;
    check_state("async_rst_issue", 16'd0, 1'b0, 28'd0);
    $display("step async reset: ip=%h valid=%b instr=%h", oIP, oValid, oInstruction);
    iReady = 1'b1;
    Reset = 1'b1;
    tick();
    check_state("restart", 16'd0, 1'b0, 28'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
